// File: rtl/periph_regbus_xbar.sv
// OBI slave to NUM_PORTS register-bus targets: window decode, demux,
// per-access timeout watchdog, port enable mask and error log.
module periph_regbus_xbar #(
   parameter int unsigned NUM_PORTS      = 8,
   parameter logic [31:0] PERIPH_BASE    = 32'h2000_0000,
   parameter int unsigned PORT_SIZE_LOG2 = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = 32'hBADC_AB1E
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [31:0]             obi_addr_i,
   input  logic                    obi_we_i,
   input  logic [3:0]              obi_be_i,
   input  logic [31:0]             obi_wdata_i,
   output logic                    obi_rvalid_o,
   output logic [31:0]             obi_rdata_o,
   output logic                    obi_err_o,
   output logic [NUM_PORTS-1:0]    reg_valid_o,
   output logic                    reg_write_o,
   output logic [31:0]             reg_addr_o,
   output logic [31:0]             reg_wdata_o,
   output logic [3:0]              reg_wstrb_o,
   input  logic [NUM_PORTS-1:0]    reg_ready_i,
   input  logic [NUM_PORTS*32-1:0] reg_rdata_i,
   input  logic [NUM_PORTS-1:0]    reg_error_i,
   input  logic [NUM_PORTS-1:0]    port_en_i,
   input  logic                    err_clr_i,
   output logic [7:0]              err_cnt_o,
   output logic [31:0]             err_addr_o,
   output logic                    timeout_irq_o
);

   localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] OFF_MASK =
      32'((64'd1 << PORT_SIZE_LOG2) - 64'd1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   state_t state_q, state_d;

   logic [31:0] addr_q;
   logic [31:0] off_q;
   logic        we_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;
   logic [IW-1:0] sel_q;
   logic [15:0] cnt_q;
   logic        to_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [7:0]  err_cnt_q;
   logic [31:0] err_addr_q;

   logic [31:0]   off;
   logic [31:0]   idx;
   logic [IW-1:0] idx_s;
   logic          hit;
   logic          en;
   logic          accept;
   logic          ready;
   logic          tout;
   logic          log_now;

   // Subtraction wraps below the base, so the explicit >= check is needed
   always_comb begin
      off   = obi_addr_i - PERIPH_BASE;
      idx   = off >> PORT_SIZE_LOG2;
      idx_s = idx[IW-1:0];
      hit   = (obi_addr_i >= PERIPH_BASE) && (idx < 32'(NUM_PORTS));
      en    = hit && port_en_i[idx_s];
   end

   assign accept  = obi_req_i && obi_gnt_o;
   assign ready   = reg_ready_i[sel_q];
   assign tout    = (cnt_q == TO_LAST) && !ready;
   assign log_now = obi_rvalid_o && obi_err_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = en ? ACCESS : RESP;
         ACCESS:  if (ready || tout) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      obi_gnt_o     = (state_q == IDLE);
      obi_rvalid_o  = (state_q == RESP);
      obi_err_o     = (state_q == RESP) && err_q;
      timeout_irq_o = (state_q == RESP) && to_q;
      reg_valid_o   = '0;
      if (state_q == ACCESS) reg_valid_o[sel_q] = 1'b1;
   end

   assign obi_rdata_o = rdata_q;
   assign reg_write_o = we_q;
   assign reg_addr_o  = off_q;
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = be_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         off_q   <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  addr_q  <= obi_addr_i;
                  off_q   <= obi_addr_i & OFF_MASK;
                  we_q    <= obi_we_i;
                  be_q    <= obi_be_i;
                  wdata_q <= obi_wdata_i;
                  sel_q   <= idx_s;
                  cnt_q   <= '0;
                  to_q    <= 1'b0;
                  err_q   <= !en;
                  rdata_q <= en ? 32'h0 : ERR_RDATA;
               end
            end
            ACCESS: begin
               cnt_q <= cnt_q + 16'd1;
               if (ready) begin
                  err_q <= reg_error_i[sel_q];
                  if (reg_error_i[sel_q]) rdata_q <= ERR_RDATA;
                  else if (we_q)          rdata_q <= 32'h0;
                  else rdata_q <= reg_rdata_i[32*sel_q +: 32];
               end else if (tout) begin
                  err_q   <= 1'b1;
                  rdata_q <= ERR_RDATA;
                  to_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Clear takes effect first so a concurrent error still gets logged
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_cnt_q  <= '0;
         err_addr_q <= '0;
      end else if (err_clr_i) begin
         err_cnt_q  <= log_now ? 8'd1 : 8'd0;
         err_addr_q <= log_now ? addr_q : 32'h0;
      end else if (log_now) begin
         if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
         err_addr_q <= addr_q;
      end
   end

   assign err_cnt_o  = err_cnt_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_periph_regbus_xbar.sv
// Directed bench for periph_regbus_xbar with a 4-cycle timeout.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_periph_regbus_xbar;

   localparam int NP = 8;
   localparam logic [31:0] ERRD = 32'hBADC_AB1E;

   logic          clk = 1'b0;
   logic          rst;
   logic          obi_req;
   logic          obi_gnt;
   logic [31:0]   obi_addr;
   logic          obi_we;
   logic [3:0]    obi_be;
   logic [31:0]   obi_wdata;
   logic          obi_rvalid;
   logic [31:0]   obi_rdata;
   logic          obi_err;
   logic [NP-1:0] reg_valid;
   logic          reg_write;
   logic [31:0]   reg_addr;
   logic [31:0]   reg_wdata;
   logic [3:0]    reg_wstrb;
   logic [NP-1:0] reg_ready;
   logic [NP*32-1:0] reg_rdata;
   logic [NP-1:0] reg_error;
   logic [NP-1:0] port_en;
   logic          err_clr;
   logic [7:0]    err_cnt;
   logic [31:0]   err_addr;
   logic          timeout_irq;

   int errors = 0;
   int checks = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   periph_regbus_xbar #(
      .NUM_PORTS(NP),
      .PERIPH_BASE(32'h2000_0000),
      .PORT_SIZE_LOG2(16),
      .TIMEOUT_CYCLES(4),
      .ERR_RDATA(ERRD)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .obi_req_i(obi_req),
      .obi_gnt_o(obi_gnt),
      .obi_addr_i(obi_addr),
      .obi_we_i(obi_we),
      .obi_be_i(obi_be),
      .obi_wdata_i(obi_wdata),
      .obi_rvalid_o(obi_rvalid),
      .obi_rdata_o(obi_rdata),
      .obi_err_o(obi_err),
      .reg_valid_o(reg_valid),
      .reg_write_o(reg_write),
      .reg_addr_o(reg_addr),
      .reg_wdata_o(reg_wdata),
      .reg_wstrb_o(reg_wstrb),
      .reg_ready_i(reg_ready),
      .reg_rdata_i(reg_rdata),
      .reg_error_i(reg_error),
      .port_en_i(port_en),
      .err_clr_i(err_clr),
      .err_cnt_o(err_cnt),
      .err_addr_o(err_addr),
      .timeout_irq_o(timeout_irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request through its acceptance edge (cycle 0)
   task automatic issue(input logic [31:0] a, input logic w,
                        input logic [31:0] d);
      obi_req   = 1'b1;
      obi_addr  = a;
      obi_we    = w;
      obi_wdata = d;
      tick();
      obi_req   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (obi_gnt !== 1'b1 || obi_rvalid !== 1'b0 || obi_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_obi gnt=%b rvalid=%b err=%b exp 1 0 0",
                  obi_gnt, obi_rvalid, obi_err);
      end
      checks++;
      if (reg_valid !== 8'h00 || obi_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs valid=%h rdata=%h exp 00 0",
                  reg_valid, obi_rdata);
      end
      checks++;
      if (err_cnt !== 8'd0 || err_addr !== 32'h0 || timeout_irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_log cnt=%0d addr=%h irq=%b exp 0 0 0",
                  err_cnt, err_addr, timeout_irq);
      end
   endtask

   task automatic test_read_hit();
      reg_ready = 8'h04;
      reg_rdata[32*2 +: 32] = 32'h1234_5678;
      issue(32'h2002_0010, 1'b0, 32'h0);
      checks++;
      if (reg_valid !== 8'h04 || reg_addr !== 32'h10 || reg_write !== 1'b0) begin
         errors++;
         $display("FAIL rd_c1 valid=%h addr=%h we=%b exp 04 10 0",
                  reg_valid, reg_addr, reg_write);
      end
      checks++;
      if (obi_gnt !== 1'b0 || obi_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rd_c1_obi gnt=%b rvalid=%b exp 0 0",
                  obi_gnt, obi_rvalid);
      end
      tick();
      checks++;
      if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h1234_5678 ||
          obi_err !== 1'b0 || reg_valid !== 8'h00) begin
         errors++;
         $display("FAIL rd_c2 rvalid=%b rdata=%h err=%b valid=%h exp 1 12345678 0 00",
                  obi_rvalid, obi_rdata, obi_err, reg_valid);
      end
      tick();
      checks++;
      if (obi_gnt !== 1'b1 || obi_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rd_c3 gnt=%b rvalid=%b exp 1 0", obi_gnt, obi_rvalid);
      end
   endtask

   task automatic test_write_wait();
      reg_ready = 8'h00;
      obi_be = 4'b0110;
      issue(32'h2003_ABCD, 1'b1, 32'hDEAD_BEEF);
      checks++;
      if (reg_valid !== 8'h08 || reg_addr !== 32'hABCD || reg_write !== 1'b1 ||
          reg_wdata !== 32'hDEAD_BEEF || reg_wstrb !== 4'b0110) begin
         errors++;
         $display("FAIL wr_c1 valid=%h addr=%h we=%b wd=%h st=%b exp 08 abcd 1 deadbeef 0110",
                  reg_valid, reg_addr, reg_write, reg_wdata, reg_wstrb);
      end
      obi_be = 4'hF;
      tick();
      checks++;
      if (reg_valid !== 8'h08 || obi_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL wr_c2 valid=%h rvalid=%b exp 08 0", reg_valid, obi_rvalid);
      end
      reg_ready = 8'h08;
      reg_rdata[32*3 +: 32] = 32'h5555_AAAA;
      tick();
      reg_ready = 8'h00;
      checks++;
      if (obi_rvalid !== 1'b1 || obi_rdata !== 32'h0 || obi_err !== 1'b0) begin
         errors++;
         $display("FAIL wr_c3 rvalid=%b rdata=%h err=%b exp 1 0 0",
                  obi_rvalid, obi_rdata, obi_err);
      end
      tick();
   endtask

   task automatic test_decode_miss();
      issue(32'h2008_0000, 1'b1, 32'h1);
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== ERRD ||
          reg_valid !== 8'h00) begin
         errors++;
         $display("FAIL miss_c1 rvalid=%b err=%b rdata=%h valid=%h exp 1 1 badcab1e 00",
                  obi_rvalid, obi_err, obi_rdata, reg_valid);
      end
      tick();
      exp_cnt = 1;
      checks++;
      if (err_cnt !== 8'(exp_cnt) || err_addr !== 32'h2008_0000) begin
         errors++;
         $display("FAIL miss_log cnt=%0d addr=%h exp %0d 20080000",
                  err_cnt, err_addr, exp_cnt);
      end
      issue(32'h1FFF_FFFC, 1'b0, 32'h0);
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || reg_valid !== 8'h00) begin
         errors++;
         $display("FAIL miss_below rvalid=%b err=%b valid=%h exp 1 1 00",
                  obi_rvalid, obi_err, reg_valid);
      end
      tick();
      exp_cnt = 2;
      checks++;
      if (err_cnt !== 8'(exp_cnt) || err_addr !== 32'h1FFF_FFFC) begin
         errors++;
         $display("FAIL miss_below_log cnt=%0d addr=%h exp %0d 1ffffffc",
                  err_cnt, err_addr, exp_cnt);
      end
   endtask

   task automatic test_timeout();
      reg_ready = 8'h00;
      issue(32'h2005_0004, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (reg_valid !== 8'h20 || obi_rvalid !== 1'b0 || timeout_irq !== 1'b0) begin
            errors++;
            $display("FAIL to_wait%0d valid=%h rvalid=%b irq=%b exp 20 0 0",
                     i, reg_valid, obi_rvalid, timeout_irq);
         end
         tick();
      end
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== ERRD ||
          timeout_irq !== 1'b1 || reg_valid !== 8'h00) begin
         errors++;
         $display("FAIL to_resp rvalid=%b err=%b rdata=%h irq=%b valid=%h exp 1 1 badcab1e 1 00",
                  obi_rvalid, obi_err, obi_rdata, timeout_irq, reg_valid);
      end
      tick();
      exp_cnt++;
      checks++;
      if (timeout_irq !== 1'b0 || obi_gnt !== 1'b1 || err_cnt !== 8'(exp_cnt) ||
          err_addr !== 32'h2005_0004) begin
         errors++;
         $display("FAIL to_after irq=%b gnt=%b cnt=%0d addr=%h exp 0 1 %0d 20050004",
                  timeout_irq, obi_gnt, err_cnt, err_addr, exp_cnt);
      end
   endtask

   task automatic test_ready_at_timeout();
      reg_ready = 8'h00;
      issue(32'h2006_0000, 1'b0, 32'h0);
      tick();
      tick();
      tick();
      reg_ready = 8'h40;
      reg_error = 8'h00;
      reg_rdata[32*6 +: 32] = 32'hCAFE_F00D;
      tick();
      reg_ready = 8'h00;
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b0 ||
          obi_rdata !== 32'hCAFE_F00D || timeout_irq !== 1'b0) begin
         errors++;
         $display("FAIL race_resp rvalid=%b err=%b rdata=%h irq=%b exp 1 0 cafef00d 0",
                  obi_rvalid, obi_err, obi_rdata, timeout_irq);
      end
      tick();
      checks++;
      if (err_cnt !== 8'(exp_cnt)) begin
         errors++;
         $display("FAIL race_log cnt=%0d exp %0d", err_cnt, exp_cnt);
      end
      // Target error on a read also reports ERR_RDATA
      reg_ready = 8'h01;
      reg_error = 8'h01;
      issue(32'h2000_0020, 1'b0, 32'h0);
      tick();
      reg_ready = 8'h00;
      reg_error = 8'h00;
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || obi_rdata !== ERRD) begin
         errors++;
         $display("FAIL tgt_err rvalid=%b err=%b rdata=%h exp 1 1 badcab1e",
                  obi_rvalid, obi_err, obi_rdata);
      end
      tick();
      exp_cnt++;
   endtask

   task automatic test_port_enable();
      port_en = 8'hFD;
      issue(32'h2001_0000, 1'b0, 32'h0);
      port_en = 8'hFF;
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b1 || reg_valid !== 8'h00) begin
         errors++;
         $display("FAIL dis_resp rvalid=%b err=%b valid=%h exp 1 1 00",
                  obi_rvalid, obi_err, reg_valid);
      end
      tick();
      exp_cnt++;
      checks++;
      if (err_cnt !== 8'(exp_cnt) || err_addr !== 32'h2001_0000) begin
         errors++;
         $display("FAIL dis_log cnt=%0d addr=%h exp %0d 20010000",
                  err_cnt, err_addr, exp_cnt);
      end
      // Dropping enable mid-access must not abort it
      reg_ready = 8'h00;
      issue(32'h2004_0008, 1'b0, 32'h0);
      port_en = 8'hEF;
      tick();
      reg_ready = 8'h10;
      reg_rdata[32*4 +: 32] = 32'h0BAD_F00D;
      checks++;
      if (reg_valid !== 8'h10) begin
         errors++;
         $display("FAIL dis_mid_valid valid=%h exp 10", reg_valid);
      end
      tick();
      reg_ready = 8'h00;
      port_en = 8'hFF;
      checks++;
      if (obi_rvalid !== 1'b1 || obi_err !== 1'b0 || obi_rdata !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL dis_mid_resp rvalid=%b err=%b rdata=%h exp 1 0 0badf00d",
                  obi_rvalid, obi_err, obi_rdata);
      end
      tick();
   endtask

   task automatic test_saturation();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err_cnt !== 8'd0 || err_addr !== 32'h0) begin
         errors++;
         $display("FAIL clr cnt=%0d addr=%h exp 0 0", err_cnt, err_addr);
      end
      for (int i = 0; i < 300; i++) begin
         issue(32'h3000_0000 + 32'(i * 4), 1'b0, 32'h0);
         tick();
      end
      checks++;
      if (err_cnt !== 8'd255 || err_addr !== 32'h3000_04AC) begin
         errors++;
         $display("FAIL sat cnt=%0d addr=%h exp 255 300004ac", err_cnt, err_addr);
      end
      issue(32'h4000_0000, 1'b1, 32'h0);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err_cnt !== 8'd1 || err_addr !== 32'h4000_0000) begin
         errors++;
         $display("FAIL clr_race cnt=%0d addr=%h exp 1 40000000",
                  err_cnt, err_addr);
      end
   endtask

   task automatic test_reset_mid_access();
      reg_ready = 8'h00;
      issue(32'h2000_0000, 1'b0, 32'h0);
      checks++;
      if (reg_valid !== 8'h01) begin
         errors++;
         $display("FAIL rst_mid_pre valid=%h exp 01", reg_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (reg_valid !== 8'h00 || obi_rvalid !== 1'b0 || obi_gnt !== 1'b1 ||
          err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rst_mid valid=%h rvalid=%b gnt=%b cnt=%0d exp 00 0 1 0",
                  reg_valid, obi_rvalid, obi_gnt, err_cnt);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (obi_rvalid !== 1'b0 || timeout_irq !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_quiet%0d rvalid=%b irq=%b exp 0 0",
                     i, obi_rvalid, timeout_irq);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      obi_req   = 1'b0;
      obi_addr  = '0;
      obi_we    = 1'b0;
      obi_be    = 4'hF;
      obi_wdata = '0;
      reg_ready = '0;
      reg_rdata = '0;
      reg_error = '0;
      port_en   = '1;
      err_clr   = 1'b0;
      #1;
      test_reset();
      test_read_hit();
      test_write_wait();
      test_decode_miss();
      test_timeout();
      test_ready_at_timeout();
      test_port_enable();
      test_saturation();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
